// File: rtl/oled_frame_streamer.sv
// Raster scan of the 96x64 PmodOLEDrgb panel: fetches RGB565 pixels and serializes them MSB-first over 4-wire SPI.
// Optional OLED_WINDOW_CMD_EN prefixes each frame with the column/row window command bytes.
module oled_frame_streamer #(
  parameter int CLK_DIV = 2,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic [6:0]  x,
  output logic [5:0]  y,
  input  logic [15:0] oled_data,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        dc,
  output logic        busy,
  output logic        frame_done
);

`ifdef OLED_WINDOW_CMD_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_FETCH, S_SHIFT, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST   = 6'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        sdin_q, sdin_d;
  logic        dc_q, dc_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        bit_end;

`ifdef OLED_WINDOW_CMD_EN
  logic [2:0] cmd_idx_q, cmd_idx_d;
  logic [7:0] cmd_val;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h15;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'h5F;
      3'd3:    cmd_byte = 8'h75;
      3'd4:    cmd_byte = 8'h00;
      3'd5:    cmd_byte = 8'h3F;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  // Byte to load next: the first one on acceptance, otherwise the successor of the current one.
  assign cmd_val = cmd_byte((state_q == S_IDLE) ? 3'd0 : cmd_idx_q + 3'd1);
`endif

  // A bit ends once the high half of sclk has run its full CLK_DIV cycles.
  assign bit_end = (div_q == DIV_LAST) && sclk_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    x_d          = x_q;
    y_d          = y_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    sdin_d       = sdin_q;
    dc_d         = dc_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
`ifdef OLED_WINDOW_CMD_EN
    cmd_idx_d    = cmd_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          busy_d = 1'b1;
          cs_n_d = 1'b0;
          div_d  = 8'd0;
          bit_d  = 4'd0;
`ifdef OLED_WINDOW_CMD_EN
          state_d   = S_CMD;
          dc_d      = 1'b0;
          sclk_d    = 1'b0;
          cmd_idx_d = 3'd0;
          sdin_d    = cmd_val[7];
          shreg_d   = {cmd_val[6:0], 9'd0};
`else
          state_d = S_FETCH;
          dc_d    = 1'b1;
`endif
        end
      end

`ifdef OLED_WINDOW_CMD_EN
      S_CMD: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q[2:0] != 3'd7) begin
            sclk_d  = 1'b0;
            sdin_d  = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end else if (cmd_idx_q == 3'd5) begin
            state_d = S_FETCH;
            dc_d    = 1'b1;
          end else begin
            cmd_idx_d = cmd_idx_q + 3'd1;
            bit_d     = bit_q + 4'd1;
            sclk_d    = 1'b0;
            sdin_d    = cmd_val[7];
            shreg_d   = {cmd_val[6:0], 9'd0};
          end
        end
      end
`endif

      S_FETCH: begin
        state_d = S_SHIFT;
        sclk_d  = 1'b0;
        sdin_d  = oled_data[15];
        shreg_d = {oled_data[14:0], 1'b0};
        div_d   = 8'd0;
        bit_d   = 4'd0;
      end

      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q != 4'd15) begin
            sclk_d  = 1'b0;
            sdin_d  = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end
        // Pixel advance is folded into the final cycle of the last bit.
        if (bit_end && bit_q == 4'd15) begin
          state_d = S_FETCH;
          if (x_q != X_LAST) begin
            x_d = x_q + 7'd1;
          end else begin
            x_d = 7'd0;
            if (y_q != Y_LAST) begin
              y_d = y_q + 6'd1;
            end else begin
              y_d          = 6'd0;
              state_d      = S_DONE;
              cs_n_d       = 1'b1;
              frame_done_d = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        dc_d         = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= 8'd0;
      bit_q        <= 4'd0;
      shreg_q      <= 16'd0;
      x_q          <= 7'd0;
      y_q          <= 6'd0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      sdin_q       <= 1'b0;
      dc_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef OLED_WINDOW_CMD_EN
      cmd_idx_q    <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      sdin_q       <= sdin_d;
      dc_q         <= dc_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef OLED_WINDOW_CMD_EN
      cmd_idx_q    <= cmd_idx_d;
`endif
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign sdin       = sdin_q;
  assign dc         = dc_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer on a reduced 8x4 frame with an SPI decoder watching the pins.
module tb_oled_frame_streamer;
  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 2;
`ifdef OLED_WINDOW_CMD_EN
  localparam int PRE = 96 * D;
  localparam logic ACC_DC = 1'b0;
`else
  localparam int PRE = 0;
  localparam logic ACC_DC = 1'b1;
`endif
  localparam int FRAME_LEN = 1 + PRE + W * H * (1 + 32 * D);

  logic clk = 1'b0;
  logic reset;
  logic frame_start;
  logic [6:0] x;
  logic [5:0] y;
  logic [15:0] oled_data;
  logic cs_n, sclk, sdin, dc, busy, frame_done;
  logic use_const;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc;
  int done_cyc;
  int done_cnt;

  logic [15:0] words[$];
  logic [7:0]  bytes[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign oled_data = use_const ? 16'hA55A : {y, x, 3'b000};

  oled_frame_streamer #(.CLK_DIV(D), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .x(x), .y(y),
    .oled_data(oled_data), .cs_n(cs_n), .sclk(sclk), .sdin(sdin), .dc(dc),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI decoder: capture on rising sclk, and require sdin to move only with a falling sclk.
  logic sclk_prev = 1'b1, sdin_prev = 1'b0, cs_prev = 1'b1;
  logic [15:0] wsh;
  logic [7:0]  bsh;
  int wbits = 0, bbits = 0;
  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      wbits = 0;
      bbits = 0;
    end else begin
      if (sclk && !sclk_prev) begin
        check("sdin_hold_at_rise", sdin, sdin_prev);
        if (dc) begin
          wsh = {wsh[14:0], sdin};
          wbits++;
          if (wbits == 16) begin words.push_back(wsh); wbits = 0; end
        end else begin
          bsh = {bsh[6:0], sdin};
          bbits++;
          if (bbits == 8) begin bytes.push_back(bsh); bbits = 0; end
        end
      end
      if (!cs_prev && sdin !== sdin_prev)
        check("sdin_change_on_fall", {30'd0, sclk_prev, sclk}, 32'd2);
    end
    if (frame_done === 1'b1) done_cnt++;
    sclk_prev = sclk;
    sdin_prev = sdin;
    cs_prev   = cs_n;
  end

  task automatic clear_mon();
    words.delete();
    bytes.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    frame_start = 1'b0;
    check("acc_busy", busy, 1'b1);
    check("acc_cs_n", cs_n, 1'b0);
    check("acc_dc", dc, ACC_DC);
    check("acc_x", x, 7'd0);
    check("acc_y", y, 6'd0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < FRAME_LEN + 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    check("done_timeout", (frame_done === 1'b1) ? 32'd1 : 32'd0, 32'd1);
    done_cyc = cyc;
  endtask

  task automatic check_words();
    check("word_count", words.size(), W * H);
    for (int k = 0; k < words.size() && k < W * H; k++)
      check($sformatf("word_%0d", k), words[k], {6'(k / W), 7'(k % W), 3'b000});
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    use_const = 1'b0;
    done_cnt = 0;
    #3;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_sdin", sdin, 1'b0);
    check("rst_dc", dc, 1'b0);
    check("rst_x", x, 7'd0);
    check("rst_y", y, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Full frame with position-coded pixel data
    clear_mon();
    start_frame();
`ifdef OLED_WINDOW_CMD_EN
    repeat (PRE - 1) @(posedge clk);
    #1 check("dc_during_cmd", dc, 1'b0);
    @(posedge clk);
    #1 check("dc_at_fetch", dc, 1'b1);
`endif
    check("sclk_in_fetch", sclk, 1'b1);
    wait_done();
    check("frame_len", done_cyc - acc_cyc + 1, FRAME_LEN);
    check("done_cs_n", cs_n, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_dc", dc, 1'b1);
    check("done_x", x, 7'd0);
    check("done_y", y, 6'd0);
    check("done_sclk", sclk, 1'b1);
    @(negedge clk);
    check("post_busy", busy, 1'b0);
    check("post_frame_done", frame_done, 1'b0);
    check("post_dc", dc, 1'b0);
    check("post_cs_n", cs_n, 1'b1);
    check_words();
    check("done_pulses", done_cnt, 1);
`ifdef OLED_WINDOW_CMD_EN
    check("cmd_count", bytes.size(), 6);
    if (bytes.size() == 6) begin
      check("cmd0", bytes[0], 8'h15);
      check("cmd1", bytes[1], 8'h00);
      check("cmd2", bytes[2], 8'h5F);
      check("cmd3", bytes[3], 8'h75);
      check("cmd4", bytes[4], 8'h00);
      check("cmd5", bytes[5], 8'h3F);
    end
`else
    check("cmd_count", bytes.size(), 0);
`endif

    // Constant pixel colour: bit timing and pixel advance
    use_const = 1'b1;
    clear_mon();
    start_frame();
    repeat (PRE + 1 + 32 * D) @(posedge clk);
    #1;
    check("pix1_x", x, 7'd1);
    check("pix1_y", y, 6'd0);
    check("pix1_fetch_sclk", sclk, 1'b1);
    @(posedge clk);
    #1 check("pix1_shift_sclk", sclk, 1'b0);
    wait_done();
    check("const_word_count", words.size(), W * H);
    if (words.size() > 0) check("const_word0", words[0], 16'hA55A);
    if (words.size() > 0) check("const_word_last", words[words.size() - 1], 16'hA55A);
    use_const = 1'b0;
    repeat (3) @(negedge clk);

    // Busy guard: start requests mid-frame and in DONE are ignored
    clear_mon();
    start_frame();
    repeat (100) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("guard_busy", busy, 1'b1);
    wait_done();
    check("guard_frame_len", done_cyc - acc_cyc + 1, FRAME_LEN);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("guard_busy_falls", busy, 1'b0);
    check("guard_cs_n", cs_n, 1'b1);
    repeat (20) @(negedge clk);
    check("guard_idle_busy", busy, 1'b0);
    check("guard_done_pulses", done_cnt, 1);
    check("guard_word_count", words.size(), W * H);

    // Mid-frame abort at pixel (5,2), bit 7, then a clean restart
    clear_mon();
    start_frame();
    begin
      int n;
      for (n = 0; n < FRAME_LEN; n++) begin
        @(negedge clk);
        if (x == 7'd5 && y == 6'd2) break;
      end
      check("abort_reach_pixel", (x == 7'd5 && y == 6'd2) ? 32'd1 : 32'd0, 32'd1);
    end
    repeat (1 + 7 * 2 * D + 1) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_sdin", sdin, 1'b0);
    check("abort_dc", dc, 1'b0);
    check("abort_x", x, 7'd0);
    check("abort_y", y, 6'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    start_frame();
    wait_done();
    check("restart_frame_len", done_cyc - acc_cyc + 1, FRAME_LEN);
    check_words();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oled_frame_streamer.md
# oled_frame_streamer

Sequential scan-and-serialize engine for the 96x64 PmodOLEDrgb panel. Sweeps pixel coordinates `x`/`y` out to the combinational pixel-colour generators (menu, replay and game screens) and samples their 16-bit RGB565 `oled_data` response. Shifts each pixel MSB-first over the panel's 4-wire SPI (`cs_n`, `sclk`, `sdin`, `dc`). Sits between the screen mux and the top-level Pmod pins, after the power-on init sequencer has configured the panel.

## Interface
Parameters:
- `CLK_DIV`, 2: `sclk` half-period in `clk` cycles; legal range 1..255.
- `WIDTH`, 96: pixels per row.
- `HEIGHT`, 64: rows per frame.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high; forces all state and outputs to their reset values.
- `frame_start` in 1: request one frame; sampled only in IDLE.
- `x` out 7: current pixel column to the colour generator.
- `y` out 6: current pixel row to the colour generator.
- `oled_data` in 16: RGB565 colour for (`x`,`y`); combinational from `x`/`y`.
- `cs_n` out 1: SPI chip select, active low.
- `sclk` out 1: SPI clock; idles high.
- `sdin` out 1: SPI data, MSB first.
- `dc` out 1: 0 = command byte, 1 = pixel data.
- `busy` out 1: high from frame acceptance through the DONE cycle.
- `frame_done` out 1: one-cycle pulse at end of frame.

## Operation
- Reset values: `cs_n`=1, `sclk`=1, `sdin`=0, `dc`=0, `x`=0, `y`=0, `busy`=0, `frame_done`=0, state=IDLE.
- States:
  - IDLE: transitions to CMD (macro on) or FETCH (macro off) when `frame_start`=1.
  - CMD: shifts the 6 command bytes, then goes to FETCH.
  - FETCH: lasts 1 cycle; `x`/`y` are stable and `oled_data` is registered into the 16-bit shift register.
  - SHIFT: shifts the 16 pixel bits, then goes to NEXT.
  - NEXT: lasts 0 cycles; merged into the last SHIFT cycle. It advances `x`, wraps `x` at WIDTH-1 to 0 with `y`+1, and returns to FETCH. After pixel (WIDTH-1, HEIGHT-1) it goes to DONE.
  - DONE: lasts 1 cycle, then goes to IDLE.
- Scan order: raster, `x` fastest.
  - Frame covers (0,0)..(95,63); 6144 pixels.
  - `x`/`y` return to 0 in DONE.
- Bit framing:
  - Each bit is CLK_DIV cycles with `sclk`=0, then CLK_DIV cycles with `sclk`=1.
  - `sdin` changes only on the high-to-low `sclk` transition; the panel samples on the rising edge.
- `sclk` stays high during FETCH and DONE.
- `cs_n` goes low on the cycle after acceptance and stays low continuously until DONE, where it returns high.
- `dc` is 0 during CMD and 1 from the first FETCH through DONE. It returns to 0 in IDLE.
- `frame_start` is ignored while `busy`=1, including the DONE cycle. No queuing.
- `reset` asserted mid-frame aborts immediately to reset values with no partial-byte completion. The panel recovers because the next frame re-asserts `cs_n`.

## Timing
- Acceptance: with `frame_start`=1 at edge N in IDLE, at N+1 `busy`=1, `cs_n`=0, state is FETCH (or CMD).
- Per pixel: 1 + 32*CLK_DIV cycles.
- Per command byte: 16*CLK_DIV cycles, back-to-back with no load gap.
- `frame_done`=1 and `cs_n`=1 in the DONE cycle; `busy`=1 in that same cycle and falls to 0 the following cycle.
- Frame length, acceptance edge to DONE inclusive:
  - Macro off: 1 + WIDTH*HEIGHT*(1+32*CLK_DIV). Default parameters give 399361 cycles.
  - Macro on: add 96*CLK_DIV. Default parameters give 399553 cycles.
- Counters:
  - Bit counter: 4 bits.
  - Divider counter: 8 bits.
  - Command index: 3 bits.
  - Pixel counters: exactly match the `x`/`y` widths; no overflow past WIDTH-1/HEIGHT-1.

## Configuration
- `OLED_WINDOW_CMD_EN` defined:
  - Each frame opens with CMD state and `dc`=0.
  - Sends bytes 0x15, 0x00, 0x5F, 0x75, 0x00, 0x3F (column window 0..95, row window 0..63) MSB first.
  - Then goes to FETCH.
- Undefined:
  - CMD state and command ROM are not compiled.
  - IDLE goes directly to FETCH.
  - The panel's address pointer must already be at (0,0).

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs take reset values before the next `clk` edge. `cs_n`=1, `sclk`=1, `busy`=0.
- Full frame, macro off, CLK_DIV=2, stub `oled_data`={`y`,`x`,3'b0}:
  - SPI monitor decodes 6144 words, word k = {k/96, k%96, 3'b0}.
  - `frame_done` pulses once, exactly 399361 cycles after acceptance.
- Bit timing, CLK_DIV=1, `oled_data`=16'hA55A:
  - `sclk` alternates every cycle, except high during FETCH.
  - `sdin` stable across each rising edge.
  - First word decodes 0xA55A.
- Busy guard: pulse `frame_start` at cycle 100 of a frame and again in the DONE cycle -> no restart and no second frame; `busy` falls once.
- Mid-frame abort: assert `reset` during pixel (40,10) bit 7 -> `cs_n`=1 immediately. A new `frame_start` restarts at `x`=0, `y`=0 with a full 6144-pixel frame.
- Macro on, CLK_DIV=2:
  - First 48 bits, with `dc`=0, decode 15 00 5F 75 00 3F.
  - `dc` rises at the first FETCH.
  - `frame_done` comes 399553 cycles after acceptance.
